uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the FSM state encoding, the parity selection and the default bit period.
package uart_pkg;

   localparam int DEFAULT_DIVISOR = 868;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port and FIFO status of the buffered UART transmitter.
// The CPU is the master; the transmitter is the slave.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);

   logic                          uartWe;
   logic [DATA_BITS-1:0]          uartData;
   logic                          ovfClear;
   logic                          full;
   logic                          empty;
   logic [$clog2(FIFO_DEPTH):0]   count;
   logic                          overflow;

   modport master (
      output uartWe, uartData, ovfClear,
      input  full, empty, count, overflow
   );

   modport slave (
      input  uartWe, uartData, ovfClear,
      output full, empty, count, overflow
   );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with a combinational head read; full/empty come from the count.
// Storage is left unreset, only pointers and occupancy are cleared.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO feeding a start/data/parity/stop serialiser.
// The head is popped in IDLE and the start bit appears on the same edge.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DIVISOR    = DEFAULT_DIVISOR,
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0
) (
   input  logic           sysclk,
   input  logic           cpu_resetn,
   uart_tx_fifo_if.slave  bus,
   output logic           busy,
   output logic           uart_tx
);

   localparam int                BAUD_W    = $clog2(DIVISOR);
   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
   localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
   localparam parity_e           PAR_MODE  = parity_e'(PARITY);

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return (PAR_MODE == PAR_ODD) ? ~(^d) : (^d);
   endfunction

   uart_state_e          state;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_reg;
   logic [DATA_BITS-1:0] head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic                 pop;
   logic                 baud_end;
   logic                 ovf_q;

   assign pop          = (state == ST_IDLE) && !fifo_empty;
   assign baud_end     = (baud_cnt == BAUD_LAST);
   assign busy         = (state != ST_IDLE);
   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.count    = fifo_count;
   assign bus.overflow = ovf_q;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (sysclk),
      .rst_n     (cpu_resetn),
      .push      (bus.uartWe),
      .push_data (bus.uartData),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A dropped write is judged on pre-edge full and beats a concurrent clear.
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         ovf_q <= 1'b0;
      end else if (bus.uartWe && fifo_full) begin
         ovf_q <= 1'b1;
      end else if (bus.ovfClear) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (pop) begin
         shift_reg <= head;
         par_reg   <= parity_bit(head);
      end else if ((state == ST_DATA) && baud_end) begin
         shift_reg <= shift_reg >> 1;
      end
   end

   // Each transition loads uart_tx with the level of the bit being entered.
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               uart_tx  <= 1'b1;
               if (!fifo_empty) begin
                  state   <= ST_START;
                  uart_tx <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
                  uart_tx  <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     if (PAR_MODE != PAR_NONE) begin
                        state   <= ST_PARITY;
                        uart_tx <= par_reg;
                     end else begin
                        state   <= ST_STOP;
                        uart_tx <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_PARITY: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_STOP;
                  uart_tx  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_STOP: begin
               uart_tx <= 1'b1;
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               baud_cnt <= '0;
               bit_idx  <= '0;
               uart_tx  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one clock and reset;
// expected line frames are queued at write time and matched by a serial monitor.
module tb_uart_tx_fifo;

   localparam int D = 4;

   logic sysclk = 1'b0;
   logic cpu_resetn = 1'b0;
   always #5 sysclk = ~sysclk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_b ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_c ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_d ();

   logic tx_a, tx_b, tx_c, tx_d;
   logic busy_a, busy_b, busy_c, busy_d;

   uart_tx_fifo #(.DIVISOR(D), .FIFO_DEPTH(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u_a (
      .sysclk(sysclk), .cpu_resetn(cpu_resetn), .bus(if_a.slave), .busy(busy_a), .uart_tx(tx_a));
   uart_tx_fifo #(.DIVISOR(D), .FIFO_DEPTH(4), .DATA_BITS(7), .STOP_BITS(1), .PARITY(2)) u_b (
      .sysclk(sysclk), .cpu_resetn(cpu_resetn), .bus(if_b.slave), .busy(busy_b), .uart_tx(tx_b));
   uart_tx_fifo #(.DIVISOR(D), .FIFO_DEPTH(4), .DATA_BITS(7), .STOP_BITS(1), .PARITY(1)) u_c (
      .sysclk(sysclk), .cpu_resetn(cpu_resetn), .bus(if_c.slave), .busy(busy_c), .uart_tx(tx_c));
   uart_tx_fifo #(.DIVISOR(D), .FIFO_DEPTH(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) u_d (
      .sysclk(sysclk), .cpu_resetn(cpu_resetn), .bus(if_d.slave), .busy(busy_d), .uart_tx(tx_d));

   logic [3:0] txv, busyv, emptyv, fullv, ovfv;
   assign txv    = {tx_d, tx_c, tx_b, tx_a};
   assign busyv  = {busy_d, busy_c, busy_b, busy_a};
   assign emptyv = {if_d.empty, if_c.empty, if_b.empty, if_a.empty};
   assign fullv  = {if_d.full, if_c.full, if_b.full, if_a.full};
   assign ovfv   = {if_d.overflow, if_c.overflow, if_b.overflow, if_a.overflow};

   typedef struct {
      int          w;
      logic [15:0] bits;
      int          nb;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] get_cnt(input int w);
      case (w)
         0:       return if_a.count;
         1:       return if_b.count;
         2:       return if_c.count;
         default: return if_d.count;
      endcase
   endfunction

   // Line-level frame: start 0, data LSB first, optional parity, stop 1s.
   function automatic exp_t make_frame(input int w, input logic [7:0] d, input int nbits,
                                       input int par, input int nstop);
      exp_t e;
      int   ones = 0;
      int   k = 0;
      e.w = w;
      e.bits = '0;
      e.bits[k] = 1'b0;
      k++;
      for (int i = 0; i < nbits; i++) begin
         e.bits[k] = d[i];
         if (d[i]) ones++;
         k++;
      end
      if (par != 0) begin
         e.bits[k] = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
         k++;
      end
      for (int i = 0; i < nstop; i++) begin
         e.bits[k] = 1'b1;
         k++;
      end
      e.nb = k;
      return e;
   endfunction

   task automatic drive(input int w, input logic we, input logic [7:0] d, input logic clr);
      case (w)
         0: begin if_a.uartWe = we; if_a.uartData = d;      if_a.ovfClear = clr; end
         1: begin if_b.uartWe = we; if_b.uartData = d[6:0]; if_b.ovfClear = clr; end
         2: begin if_c.uartWe = we; if_c.uartData = d[6:0]; if_c.ovfClear = clr; end
         default: begin if_d.uartWe = we; if_d.uartData = d; if_d.ovfClear = clr; end
      endcase
      @(negedge sysclk);
   endtask

   task automatic capture(input int w, output int waited);
      exp_t        e;
      logic [15:0] obs;
      int          busy_n;
      logic        glitch;
      waited = 0;
      do begin
         @(negedge sysclk);
         waited++;
      end while (txv[w] !== 1'b0 && waited < 400);
      if (txv[w] !== 1'b0) begin
         chk("start_timeout", 32'(txv[w]), 0);
         return;
      end
      if (sb.size() == 0) begin
         chk("unexpected_frame", 32'(sb.size()), 1);
         return;
      end
      e = sb.pop_front();
      obs = '0;
      glitch = 1'b0;
      busy_n = 0;
      for (int k = 0; k < e.nb; k++) begin
         for (int c = 0; c < D; c++) begin
            if (!(k == 0 && c == 0)) @(negedge sysclk);
            if (c == 0) obs[k] = txv[w];
            else if (txv[w] !== obs[k]) glitch = 1'b1;
            if (busyv[w] === 1'b1) busy_n++;
         end
      end
      @(negedge sysclk);
      chk("idle_busy_low", 32'(busyv[w]), 0);
      chk("frame_bits", 32'(obs), 32'(e.bits));
      chk("busy_cycles", busy_n, e.nb * D);
      chk("bit_stable", 32'(glitch), 0);
   endtask

   task automatic run_single(input int w, input logic [7:0] d, input int nbits,
                             input int par, input int nstop);
      int waited;
      sb.push_back(make_frame(w, d, nbits, par, nstop));
      fork
         begin
            drive(w, 1'b1, d, 1'b0);
            chk("tx_high_after_write_edge", 32'(txv[w]), 1);
            chk("empty_after_push", 32'(emptyv[w]), 0);
            chk("count_after_push", 32'(get_cnt(w)), 1);
            drive(w, 1'b0, 8'h00, 1'b0);
            chk("tx_start_low", 32'(txv[w]), 0);
            chk("busy_at_start", 32'(busyv[w]), 1);
            chk("empty_after_pop", 32'(emptyv[w]), 1);
         end
         capture(w, waited);
      join
      chk("start_latency", waited, 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int lows;
      for (int w = 0; w < 4; w++) begin
         case (w)
            0: begin if_a.uartWe = 0; if_a.uartData = '0; if_a.ovfClear = 0; end
            1: begin if_b.uartWe = 0; if_b.uartData = '0; if_b.ovfClear = 0; end
            2: begin if_c.uartWe = 0; if_c.uartData = '0; if_c.ovfClear = 0; end
            default: begin if_d.uartWe = 0; if_d.uartData = '0; if_d.ovfClear = 0; end
         endcase
      end
      cpu_resetn = 1'b0;
      repeat (3) @(negedge sysclk);
      for (int w = 0; w < 4; w += 3) begin
         chk("rst_tx", 32'(txv[w]), 1);
         chk("rst_busy", 32'(busyv[w]), 0);
         chk("rst_overflow", 32'(ovfv[w]), 0);
         chk("rst_empty", 32'(emptyv[w]), 1);
         chk("rst_full", 32'(fullv[w]), 0);
         chk("rst_count", 32'(get_cnt(w)), 0);
      end
      cpu_resetn = 1'b1;
      repeat (2) @(negedge sysclk);
      chk("no_frame_without_write", 32'(busyv), 0);

      run_single(0, 8'hA5, 8, 0, 1);
      run_single(1, 8'h03, 7, 2, 1);
      run_single(2, 8'h03, 7, 1, 1);
      run_single(3, 8'hFF, 8, 0, 2);

      // Six back-to-back writes into a depth-4 FIFO: the last one is dropped.
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               if (i <= 5) sb.push_back(make_frame(0, 8'(i), 8, 0, 1));
               if (i == 6) chk("full_before_drop", 32'(fullv[0]), 1);
               drive(0, 1'b1, 8'(i), 1'b0);
            end
            chk("overflow_set", 32'(ovfv[0]), 1);
            chk("count_full", 32'(get_cnt(0)), 4);
            drive(0, 1'b0, 8'h00, 1'b0);
         end
         for (int i = 0; i < 5; i++) begin
            capture(0, waited);
            if (i > 0) chk("inter_frame_gap", waited, 1);
         end
      join
      chk("drained_empty", 32'(emptyv[0]), 1);

      // Clear racing a dropped write must lose; a lone clear must win.
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               sb.push_back(make_frame(0, 8'h11 + 8'(i), 8, 0, 1));
               drive(0, 1'b1, 8'h11 + 8'(i), 1'b0);
            end
            chk("full_refilled", 32'(fullv[0]), 1);
            drive(0, 1'b1, 8'h16, 1'b1);
            chk("ovf_kept_on_drop_and_clear", 32'(ovfv[0]), 1);
            drive(0, 1'b0, 8'h00, 1'b1);
            chk("ovf_cleared", 32'(ovfv[0]), 0);
            drive(0, 1'b0, 8'h00, 1'b0);
         end
         for (int i = 0; i < 5; i++) begin
            capture(0, waited);
            if (i > 0) chk("inter_frame_gap2", waited, 1);
         end
      join

      // Reset in the middle of data bit 3 with two entries still queued.
      drive(0, 1'b1, 8'h00, 1'b0);
      drive(0, 1'b1, 8'h55, 1'b0);
      drive(0, 1'b1, 8'hAA, 1'b0);
      drive(0, 1'b0, 8'h00, 1'b0);
      chk("queued_two", 32'(get_cnt(0)), 2);
      repeat (15) @(negedge sysclk);
      chk("mid_frame_line_low", 32'(txv[0]), 0);
      chk("mid_frame_busy", 32'(busyv[0]), 1);
      #2 cpu_resetn = 1'b0;
      #1;
      chk("abort_tx_high", 32'(txv[0]), 1);
      chk("abort_count", 32'(get_cnt(0)), 0);
      chk("abort_empty", 32'(emptyv[0]), 1);
      chk("abort_busy", 32'(busyv[0]), 0);
      @(negedge sysclk);
      cpu_resetn = 1'b1;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sysclk);
         if (txv[0] !== 1'b1 || busyv[0] !== 1'b0) lows++;
      end
      chk("quiet_after_release", lows, 0);
      run_single(0, 8'h3C, 8, 0, 1);

      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
